// File: rtl/core_pkg.sv
// Shared opcode and FSM state types for the ALU with iterative multiply/divide.
// Opcode helpers classify operations and their operand signedness.
package core_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLTS   = 5'd2,
        ALU_SLTU   = 5'd3,
        ALU_AND    = 5'd4,
        ALU_OR     = 5'd5,
        ALU_XOR    = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } alu_state_e;

    function automatic logic is_single(input alu_opcode_e op);
        return op inside {ALU_ADD, ALU_SUB, ALU_SLTS, ALU_SLTU, ALU_AND,
                          ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA};
    endfunction

    function automatic logic is_multi(input alu_opcode_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    // Operand A is treated as signed by these ops; operand B by a subset.
    function automatic logic a_signed(input alu_opcode_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    endfunction

    function automatic logic b_signed(input alu_opcode_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider on operand magnitudes.
// After WIDTH run cycles {o_hi,o_lo} holds the product, or o_lo/o_hi hold quotient/remainder.
module alu_muldiv_iter
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_run,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_mag_a,
    input  logic [WIDTH-1:0] i_mag_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_last
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic             r_div;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;

    // Multiply: r_lo holds the multiplier shifting out, product bits shift in from the top.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    // Divide: r_lo holds the dividend shifting out, quotient bits shift in from the bottom.
    assign w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_opnd};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_div   <= 1'b0;
        end else if (i_start) begin
            r_count <= CW'(WIDTH - 1);
            r_hi    <= '0;
            r_lo    <= i_mag_a;
            r_opnd  <= i_mag_b;
            r_div   <= i_is_div;
        end else if (i_run) begin
            if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
            if (r_div) begin
                if (!w_diff[WIDTH]) begin
                    r_hi <= w_diff[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                end else begin
                    r_hi <= w_rem_sh[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_hi <= w_mul_sum[WIDTH:1];
                r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_last = (r_count == '0);

endmodule

// File: rtl/alu_muldiv.sv
// ALU with single-cycle integer ops and a fixed-latency iterative multiply/divide.
// Handshake: a request is taken on a rising edge with enable=1, ready=1, flush=0; valid pulses one cycle.
module alu_muldiv
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_enable_ip,
    input  alu_opcode_e      alu_operator_ip,
    input  logic [WIDTH-1:0] alu_operand_a_ip,
    input  logic [WIDTH-1:0] alu_operand_b_ip,
    input  logic             alu_flush_ip,
    output logic             alu_ready_op,
    output logic [WIDTH-1:0] alu_result_op,
    output logic             alu_valid_op,
    output alu_state_e       alu_state_op
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_e       r_state, w_state_nxt;
    alu_opcode_e      r_op;
    logic [WIDTH-1:0] r_a, r_b;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_valid, w_valid_nxt;
    logic             w_start;

    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH-1:0]   w_hi, w_lo;
    logic               w_last;
    logic               w_sa, w_sb;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0]   w_quot, w_rem, w_fix;

    assign w_shamt = alu_operand_b_ip[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (alu_operator_ip)
            ALU_ADD:  w_alu = alu_operand_a_ip + alu_operand_b_ip;
            ALU_SUB:  w_alu = alu_operand_a_ip - alu_operand_b_ip;
            ALU_SLTS: w_alu = {{(WIDTH-1){1'b0}}, $signed(alu_operand_a_ip) < $signed(alu_operand_b_ip)};
            ALU_SLTU: w_alu = {{(WIDTH-1){1'b0}}, alu_operand_a_ip < alu_operand_b_ip};
            ALU_AND:  w_alu = alu_operand_a_ip & alu_operand_b_ip;
            ALU_OR:   w_alu = alu_operand_a_ip | alu_operand_b_ip;
            ALU_XOR:  w_alu = alu_operand_a_ip ^ alu_operand_b_ip;
            ALU_SLL:  w_alu = alu_operand_a_ip << w_shamt;
            ALU_SRL:  w_alu = alu_operand_a_ip >> w_shamt;
            ALU_SRA:  w_alu = $unsigned($signed(alu_operand_a_ip) >>> w_shamt);
            default:  w_alu = '0;
        endcase
    end

    assign w_mag_a = (a_signed(alu_operator_ip) && alu_operand_a_ip[WIDTH-1]) ? -alu_operand_a_ip : alu_operand_a_ip;
    assign w_mag_b = (b_signed(alu_operator_ip) && alu_operand_b_ip[WIDTH-1]) ? -alu_operand_b_ip : alu_operand_b_ip;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_run    (r_state == ST_ITER),
        .i_is_div (alu_operator_ip inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}),
        .i_mag_a  (w_mag_a),
        .i_mag_b  (w_mag_b),
        .o_hi     (w_hi),
        .o_lo     (w_lo),
        .o_last   (w_last)
    );

    // Sign correction of the magnitude result; remainder follows the dividend.
    assign w_sa     = a_signed(r_op) & r_a[WIDTH-1];
    assign w_sb     = b_signed(r_op) & r_b[WIDTH-1];
    assign w_prod   = {w_hi, w_lo};
    assign w_prod_s = (w_sa ^ w_sb) ? -w_prod : w_prod;
    assign w_quot   = (w_sa ^ w_sb) ? -w_lo : w_lo;
    assign w_rem    = w_sa ? -w_hi : w_hi;

    always_comb begin
        w_fix = '0;
        case (r_op)
            ALU_MUL:                         w_fix = w_prod_s[WIDTH-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: w_fix = w_prod_s[2*WIDTH-1:WIDTH];
            ALU_DIV, ALU_DIVU:               w_fix = (r_b == '0) ? '1 : w_quot;
            ALU_REM, ALU_REMU:               w_fix = (r_b == '0) ? r_a : w_rem;
            default:                         w_fix = '0;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_valid_nxt  = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (alu_enable_ip && !alu_flush_ip) begin
                    if (is_single(alu_operator_ip)) begin
                        w_result_nxt = w_alu;
                        w_valid_nxt  = 1'b1;
                    end else if (is_multi(alu_operator_ip)) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_ITER;
                    end else begin
                        w_result_nxt = '0;
                    end
                end
            end
            ST_ITER: begin
                if (alu_flush_ip) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_nxt = ST_IDLE;
                if (!alu_flush_ip) begin
                    w_result_nxt = w_fix;
                    w_valid_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_op     <= ALU_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_valid  <= w_valid_nxt;
            if (w_start) begin
                r_op <= alu_operator_ip;
                r_a  <= alu_operand_a_ip;
                r_b  <= alu_operand_b_ip;
            end
        end
    end

    assign alu_ready_op  = (r_state == ST_IDLE);
    assign alu_result_op = r_result;
    assign alu_valid_op  = r_valid;
    assign alu_state_op  = r_state;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed, table-driven bench for alu_muldiv at WIDTH=32 with hand-computed expectations.
module tb_alu_muldiv;
    import core_pkg::*;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          enable;
    alu_opcode_e   op;
    logic [W-1:0]  opa, opb;
    logic          flush;
    logic          ready;
    logic [W-1:0]  result;
    logic          valid;
    alu_state_e    state;

    int checks = 0;
    int errors = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .alu_enable_ip    (enable),
        .alu_operator_ip  (op),
        .alu_operand_a_ip (opa),
        .alu_operand_b_ip (opb),
        .alu_flush_ip     (flush),
        .alu_ready_op     (ready),
        .alu_result_op    (result),
        .alu_valid_op     (valid),
        .alu_state_op     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        alu_opcode_e op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one request, wait (bounded) for valid, check latency, busy span, result and hold.
    task automatic run_op(input string name, input alu_opcode_e o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int lat_exp);
        int lat;
        int nbusy;
        @(negedge clk);
        enable = 1'b1; op = o; opa = a; opb = b;
        check({name, "_ready_in"}, W'(ready), W'(1));
        @(posedge clk); #1;
        enable = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!valid && lat < 60) begin
            if (!ready) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, W'(lat), W'(lat_exp));
        check({name, "_busy"}, W'(nbusy), W'(lat_exp - 1));
        check({name, "_result"}, result, exp);
        check({name, "_ready_at_valid"}, W'(ready), W'(1));
        @(posedge clk); #1;
        check({name, "_pulse"}, W'(valid), W'(0));
        check({name, "_hold"}, result, exp);
    endtask

    task automatic count_valids(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            if (valid) n++;
        end
    endtask

    initial begin
        int nv;
        enable = 1'b0; op = ALU_ADD; opa = '0; opb = '0; flush = 1'b0;
        reset = 1'b0;
        #1;
        check("reset_valid", W'(valid), W'(0));
        check("reset_result", result, '0);
        check("reset_ready", W'(ready), W'(1));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        vecs.push_back('{"add_ovf", ALU_ADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1});
        vecs.push_back('{"sub",     ALU_SUB,    32'h00000005, 32'h00000009, 32'hFFFFFFFC, 1});
        vecs.push_back('{"slts",    ALU_SLTS,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
        vecs.push_back('{"sltu",    ALU_SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
        vecs.push_back('{"and",     ALU_AND,    32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1});
        vecs.push_back('{"or",      ALU_OR,     32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1});
        vecs.push_back('{"xor",     ALU_XOR,    32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1});
        vecs.push_back('{"sll_mask",ALU_SLL,    32'h00000001, 32'h00000021, 32'h00000002, 1});
        vecs.push_back('{"srl_mask",ALU_SRL,    32'h80000000, 32'hFFFFFFFF, 32'h00000001, 1});
        vecs.push_back('{"sra",     ALU_SRA,    32'h80000000, 32'h00000004, 32'hF8000000, 1});
        vecs.push_back('{"mulh_min",ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34});
        vecs.push_back('{"mul_min", ALU_MUL,    32'h80000000, 32'h80000000, 32'h00000000, 34});
        vecs.push_back('{"mulhu",   ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
        vecs.push_back('{"mulhsu",  ALU_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34});
        vecs.push_back('{"mul",     ALU_MUL,    32'h00003039, 32'h00000064, 32'h0012D644, 34});
        vecs.push_back('{"mul_neg", ALU_MUL,    32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 34});
        vecs.push_back('{"divu_z",  ALU_DIVU,   32'h00000007, 32'h00000000, 32'hFFFFFFFF, 34});
        vecs.push_back('{"remu_z",  ALU_REMU,   32'h00000007, 32'h00000000, 32'h00000007, 34});
        vecs.push_back('{"div_ovf", ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34});
        vecs.push_back('{"rem_ovf", ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34});
        vecs.push_back('{"div_neg", ALU_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34});
        vecs.push_back('{"rem_neg", ALU_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34});
        vecs.push_back('{"div_z",   ALU_DIV,    32'h00000007, 32'h00000000, 32'hFFFFFFFF, 34});
        vecs.push_back('{"rem_z",   ALU_REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 34});
        vecs.push_back('{"divu",    ALU_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 34});
        vecs.push_back('{"remu",    ALU_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 34});
        vecs.push_back('{"div_nb",  ALU_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 34});
        vecs.push_back('{"rem_nb",  ALU_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34});

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Back-to-back single-cycle requests on consecutive edges.
        @(negedge clk);
        enable = 1'b1; op = ALU_ADD; opa = 32'd1; opb = 32'd2;
        @(posedge clk); #1;
        check("b2b_first_valid", W'(valid), W'(1));
        check("b2b_first_result", result, 32'd3);
        op = ALU_SUB; opa = 32'd10; opb = 32'd4;
        @(posedge clk); #1;
        enable = 1'b0;
        check("b2b_second_valid", W'(valid), W'(1));
        check("b2b_second_result", result, 32'd6);

        // Flush a DIVU in flight at cycle 10.
        @(negedge clk);
        enable = 1'b1; op = ALU_DIVU; opa = 32'd1000; opb = 32'd3;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_valid", W'(valid), W'(0));
        check("flush_ready", W'(ready), W'(1));
        count_valids(40, nv);
        check("flush_no_pulse", W'(nv), W'(0));
        check("flush_result_held", result, 32'd6);
        run_op("add_after_flush", ALU_ADD, 32'd3, 32'd4, 32'd7, 1);

        // Flush in IDLE wins over enable.
        @(negedge clk);
        enable = 1'b1; flush = 1'b1; op = ALU_ADD; opa = 32'd100; opb = 32'd1;
        @(posedge clk); #1;
        enable = 1'b0; flush = 1'b0;
        check("idle_flush_valid", W'(valid), W'(0));
        check("idle_flush_result", result, 32'd7);
        check("idle_flush_ready", W'(ready), W'(1));

        // Unrecognised opcode: accepted, result cleared, no pulse.
        @(negedge clk);
        enable = 1'b1; op = alu_opcode_e'(5'd20); opa = 32'h1234; opb = 32'h5678;
        @(posedge clk); #1;
        enable = 1'b0;
        check("badop_valid", W'(valid), W'(0));
        check("badop_result", result, '0);
        check("badop_ready", W'(ready), W'(1));

        // Put a nonzero result in place, then reset in the middle of a MUL.
        run_op("add_pre_reset", ALU_ADD, 32'd20, 32'd22, 32'd42, 1);
        @(negedge clk);
        enable = 1'b1; op = ALU_MUL; opa = 32'd3; opb = 32'd5;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_result", result, '0);
        check("async_reset_valid", W'(valid), W'(0));
        check("async_reset_ready", W'(ready), W'(1));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_reset_ready", W'(ready), W'(1));
        count_valids(40, nv);
        check("reset_no_pulse", W'(nv), W'(0));
        run_op("sub_after_reset", ALU_SUB, 32'd5, 32'd9, 32'hFFFFFFFC, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
